// File: rtl/mii_debug_capture.sv
// mii_debug_capture: samples CHANNELS MII rx/tx streams into a circular buffer with a
// pre-trigger window, triggering on a frame start or external event; registered read port.
module mii_debug_capture #(
    parameter int CHANNELS = 2,
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 256,
    parameter int PRE_TRIG = 64,
    localparam int CW = 2*DATA_W + 3,
    localparam int SW = CHANNELS*CW,
    localparam int AW = $clog2(DEPTH),
    localparam int TW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sample_en,
    input  logic [CHANNELS*DATA_W-1:0] mii_rxd,
    input  logic [CHANNELS-1:0]        mii_rxdv,
    input  logic [CHANNELS-1:0]        mii_rxer,
    input  logic [CHANNELS*DATA_W-1:0] mii_txd,
    input  logic [CHANNELS-1:0]        mii_txen,
    input  logic                       arm,
    input  logic                       abort,
    input  logic [TW-1:0]              trig_ch,
    input  logic [1:0]                 trig_mode,
    input  logic                       trig_ext,
    input  logic [AW-1:0]              rd_addr,
    output logic [SW-1:0]              rd_data,
    output logic                       busy,
    output logic                       triggered,
    output logic                       done
);
    typedef enum logic [2:0] {IDLE, PRE, WAIT, POST, DONE} state_t;

    localparam int NT = 1 << TW;
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PRE_N  = PW'(PRE_TRIG);
    localparam logic [PW-1:0] POST_N = PW'(DEPTH - PRE_TRIG);

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, trig_ptr_q, trig_ptr_d;
    logic [PW-1:0]       pre_cnt_q, pre_cnt_d, post_cnt_q, post_cnt_d;
    logic [CHANNELS-1:0] prev_rxdv_q, prev_rxdv_d, prev_txen_q, prev_txen_d;
    logic                busy_q, busy_d, done_q, done_d, triggered_q, triggered_d;
    logic [SW-1:0]       rd_data_q, rd_data_d, sample;
    logic [SW-1:0]       mem [DEPTH];
    logic [NT-1:0]       rxdv_x, txen_x, prev_rxdv_x, prev_txen_x;
    logic                rx_rise, tx_rise, hit, wr_en;
    logic [AW-1:0]       rd_idx;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign sample[g*CW +: CW] = {mii_txen[g], mii_txd[g*DATA_W +: DATA_W], mii_rxer[g],
                                     mii_rxdv[g], mii_rxd[g*DATA_W +: DATA_W]};
    end

    // Widen to a power of two so any trig_ch value indexes safely (unused channels read 0).
    assign rxdv_x      = NT'(mii_rxdv);
    assign txen_x      = NT'(mii_txen);
    assign prev_rxdv_x = NT'(prev_rxdv_q);
    assign prev_txen_x = NT'(prev_txen_q);
    assign rx_rise     = rxdv_x[trig_ch] & ~prev_rxdv_x[trig_ch];
    assign tx_rise     = txen_x[trig_ch] & ~prev_txen_x[trig_ch];
    assign hit         = (trig_mode == 2'd0) ? rx_rise :
                         (trig_mode == 2'd1) ? tx_rise :
                         (trig_mode == 2'd2) ? trig_ext : (rx_rise | trig_ext);
    assign wr_en       = sample_en && (state_q inside {PRE, WAIT, POST});
    assign rd_idx      = trig_ptr_q - AW'(PRE_TRIG) + rd_addr;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        trig_ptr_d  = trig_ptr_q;
        pre_cnt_d   = pre_cnt_q;
        post_cnt_d  = post_cnt_q;
        triggered_d = triggered_q;
        prev_rxdv_d = sample_en ? mii_rxdv : prev_rxdv_q;
        prev_txen_d = sample_en ? mii_txen : prev_txen_q;
        rd_data_d   = mem[rd_idx];
        if (abort) begin
            state_d     = IDLE;
            triggered_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: if (arm) begin
                    state_d     = (PRE_TRIG == 0) ? WAIT : PRE;
                    wr_ptr_d    = '0;
                    pre_cnt_d   = '0;
                    post_cnt_d  = '0;
                    prev_rxdv_d = '0;
                    prev_txen_d = '0;
                    triggered_d = 1'b0;
                end
                PRE: if (sample_en) begin
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    pre_cnt_d = pre_cnt_q + 1'b1;
                    state_d   = (pre_cnt_q + 1'b1 == PRE_N) ? WAIT : PRE;
                end
                WAIT: if (sample_en) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    if (hit) begin
                        trig_ptr_d  = wr_ptr_q;
                        triggered_d = 1'b1;
                        post_cnt_d  = PW'(1);
                        state_d     = (POST_N == PW'(1)) ? DONE : POST;
                    end
                end
                POST: if (sample_en) begin
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    post_cnt_d = post_cnt_q + 1'b1;
                    state_d    = (post_cnt_q + 1'b1 == POST_N) ? DONE : POST;
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = state_d inside {PRE, WAIT, POST};
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= sample;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            trig_ptr_q  <= '0;
            pre_cnt_q   <= '0;
            post_cnt_q  <= '0;
            prev_rxdv_q <= '0;
            prev_txen_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            triggered_q <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            trig_ptr_q  <= trig_ptr_d;
            pre_cnt_q   <= pre_cnt_d;
            post_cnt_q  <= post_cnt_d;
            prev_rxdv_q <= prev_rxdv_d;
            prev_txen_q <= prev_txen_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            triggered_q <= triggered_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign triggered = triggered_q;
endmodule

// File: tb/tb_mii_debug_capture.sv
// tb_mii_debug_capture: table of capture scenarios with known trigger points; read-back
// expectations come from the bench's own history of strobed samples via a scoreboard queue.
module tb_mii_debug_capture;
    localparam int CH = 2, DW = 4, DEPTH = 16, PRE = 4;
    localparam int CW = 2*DW + 3, SW = CH*CW, AW = 4;

    typedef struct {
        logic [7:0] rxd;
        logic [1:0] rxdv;
        logic [1:0] rxer;
        logic [7:0] txd;
        logic [1:0] txen;
        logic       ext;
    } samp_t;

    typedef struct {
        logic [1:0] mode;
        logic       ch;
        int         gap;
        int         trig;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, sample_en = 1'b0;
    logic [7:0]    mii_rxd = '0, mii_txd = '0;
    logic [1:0]    mii_rxdv = '0, mii_rxer = '0, mii_txen = '0, trig_mode = '0;
    logic          arm = 1'b0, abort = 1'b0, trig_ch = 1'b0, trig_ext = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [SW-1:0] rd_data;
    logic          busy, triggered, done;

    int checks = 0, failures = 0;
    logic [SW-1:0] hist[$];
    logic [SW-1:0] exp_q[$];
    vec_t vecs[5];
    samp_t junk;

    mii_debug_capture #(.CHANNELS(CH), .DATA_W(DW), .DEPTH(DEPTH), .PRE_TRIG(PRE)) dut (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .mii_rxd(mii_rxd), .mii_rxdv(mii_rxdv),
        .mii_rxer(mii_rxer), .mii_txd(mii_txd), .mii_txen(mii_txen), .arm(arm), .abort(abort),
        .trig_ch(trig_ch), .trig_mode(trig_mode), .trig_ext(trig_ext), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .triggered(triggered), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [SW-1:0] pack(input samp_t r);
        logic [SW-1:0] w;
        for (int c = 0; c < CH; c++)
            w[c*CW +: CW] = {r.txen[c], r.txd[c*DW +: DW], r.rxer[c], r.rxdv[c], r.rxd[c*DW +: DW]};
        return w;
    endfunction

    function automatic samp_t gen(input int s, input int i);
        samp_t r;
        r.rxd  = 8'($urandom);
        r.rxdv = 2'($urandom);
        r.rxer = 2'($urandom);
        r.txd  = 8'($urandom);
        r.txen = 2'($urandom);
        r.ext  = 1'($urandom);
        case (s)
            0: begin r.rxd[3:0] = i[3:0]; r.rxdv[0] = (i >= 9); end
            1: begin r.rxdv[0] = i[0]; r.txen[0] = i[1]; r.txen[1] = (i >= 19); end
            2: r.rxdv[0] = (i != 0) && (i != 5);
            3: begin r.ext = (i == 2) || (i == 10); r.rxdv[0] = (i >= 6); end
            default: begin r.rxdv[1] = ((i >= 3) && (i < 8)) || (i >= 12); r.ext = (i == 1); end
        endcase
        return r;
    endfunction

    task automatic drive(input samp_t r, input logic se);
        mii_rxd = r.rxd; mii_rxdv = r.rxdv; mii_rxer = r.rxer;
        mii_txd = r.txd; mii_txen = r.txen; trig_ext = r.ext; sample_en = se;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_trig"}, triggered, 0);
    endtask

    // Runs scenario s; stop >= 0 returns right after that sample is written.
    task automatic run_cap(input int s, input int stop);
        vec_t v;
        int n;
        samp_t r;
        v = vecs[s];
        n = v.trig + DEPTH - PRE;
        trig_mode = v.mode;
        trig_ch = v.ch;
        hist.delete();
        drive(junk, 1'b0);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk($sformatf("s%0d_arm_busy", s), busy, 1);
        chk($sformatf("s%0d_arm_done", s), done, 0);
        chk($sformatf("s%0d_arm_trig", s), triggered, 0);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < v.gap - 1; j++) begin
                drive(junk, 1'b0);
                tick();
            end
            r = gen(s, i);
            hist.push_back(pack(r));
            drive(r, 1'b1);
            if (s == 1 && i == 12) arm = 1'b1;
            tick();
            arm = 1'b0;
            chk($sformatf("s%0d_i%0d_trig", s, i), triggered, (i >= v.trig) ? 1 : 0);
            chk($sformatf("s%0d_i%0d_done", s, i), done, (i == n - 1) ? 1 : 0);
            chk($sformatf("s%0d_i%0d_busy", s, i), busy, (i < n - 1) ? 1 : 0);
            if (i == stop) return;
        end
        for (int j = 0; j < 3; j++) begin
            drive(junk, 1'b1);
            tick();
        end
        drive(junk, 1'b0);
        chk($sformatf("s%0d_done_hold", s), done, 1);
        for (int k = 0; k <= DEPTH; k++) begin
            rd_addr = AW'(k % DEPTH);
            exp_q.push_back(hist[v.trig - PRE + (k % DEPTH)]);
            tick();
            chk($sformatf("s%0d_rd%0d", s, k), rd_data, exp_q.pop_front());
        end
        exp_q.push_back(hist[v.trig - PRE]);
        tick();
        chk($sformatf("s%0d_rd_hold", s), rd_data, exp_q.pop_front());
    endtask

    initial begin
        samp_t r;
        vecs[0] = '{mode: 2'd0, ch: 1'b0, gap: 1, trig: 9};
        vecs[1] = '{mode: 2'd1, ch: 1'b1, gap: 1, trig: 19};
        vecs[2] = '{mode: 2'd0, ch: 1'b0, gap: 4, trig: 6};
        vecs[3] = '{mode: 2'd2, ch: 1'b0, gap: 1, trig: 10};
        vecs[4] = '{mode: 2'd3, ch: 1'b1, gap: 2, trig: 12};
        junk = '{rxd: 8'hFF, rxdv: 2'b11, rxer: 2'b11, txd: 8'hFF, txen: 2'b11, ext: 1'b1};

        repeat (3) tick();
        check_idle("reset");
        chk("reset_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();
        check_idle("post_reset");

        for (int s = 0; s < 5; s++) run_cap(s, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_done");

        run_cap(0, 13);
        drive(gen(0, 14), 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_idle("abort_post");
        tick();
        check_idle("abort_idle");
        arm = 1'b1;
        abort = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b0;
        check_idle("arm_abort");
        run_cap(0, -1);

        rd_addr = AW'(5);
        run_cap(0, 12);
        #2 rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        chk("async_rst_rd", rd_data, 0);
        tick();
        rst_n = 1'b1;
        trig_mode = 2'd3;
        for (int i = 0; i < 20; i++) begin
            r = gen(1, i);
            r.rxdv = {2{i[0]}};
            r.ext = i[1];
            drive(r, 1'b1);
            tick();
            check_idle($sformatf("rst_idle%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mii_debug_capture.md
# mii_debug_capture

Parametrised multi-channel MII debug capture block for PHY bring-up. Samples the rx/tx nibble streams of CHANNELS MII ports into a circular buffer with a configurable pre-trigger window. Triggers on a frame start (rxdv or txen rising edge) on a selected channel, or on an external trigger. Captured samples are read back through a simple registered read port, for the Identify/JTAG debug path or a fabric APB shim.

## Interface
Parameters:
- CHANNELS, 2, number of MII ports captured (1-8)
- DATA_W, 4, rxd/txd width per channel (4 for MII, 8 for GMII)
- DEPTH, 256, buffer depth in samples; power of two, >= 4
- PRE_TRIG, 64, samples retained before the trigger sample; 0 <= PRE_TRIG < DEPTH
- Derived: CW = 2*DATA_W+3 bits per channel; SW = CHANNELS*CW; AW = log2(DEPTH)

Ports:
- clk  in  1  capture clock; all inputs synchronous to it
- rst_n  in  1  asynchronous, active-low reset
- sample_en  in  1  one-cycle strobe qualifying a sample (e.g. synchronised rxc edge)
- mii_rxd  in  CHANNELS*DATA_W  receive data, channel n at [n*DATA_W +: DATA_W]
- mii_rxdv  in  CHANNELS  receive data valid
- mii_rxer  in  CHANNELS  receive error
- mii_txd  in  CHANNELS*DATA_W  transmit data
- mii_txen  in  CHANNELS  transmit enable
- arm  in  1  start-capture pulse
- abort  in  1  cancel-capture pulse
- trig_ch  in  log2(CHANNELS) max 1  trigger channel select
- trig_mode  in  2  0=rxdv rise, 1=txen rise, 2=trig_ext, 3=rxdv rise OR trig_ext
- trig_ext  in  1  external trigger level, sampled on sample_en
- rd_addr  in  AW  read index; 0 = oldest captured sample
- rd_data  out  SW  sample word; channel n at [n*CW +: CW] = {txen, txd, rxer, rxdv, rxd}
- busy  out  1  capture in progress
- triggered  out  1  trigger seen in current/last capture
- done  out  1  capture complete, buffer readable

## Operation
- States: IDLE, PRE, WAIT, POST, DONE. Reset -> IDLE; all outputs 0; wr_ptr, counters and previous-sample registers cleared.
- IDLE/DONE: arm -> PRE (-> WAIT directly when PRE_TRIG=0); wr_ptr, pre/post counters and prev rxdv/txen cleared; done, triggered cleared.
- PRE: each sample_en writes the sample at wr_ptr, wr_ptr = (wr_ptr+1) mod DEPTH, pre_cnt++. Move to WAIT after the PRE_TRIG-th write. Triggers are ignored in PRE.
- WAIT: each sample_en writes the sample (circular overwrite). Trigger when the written sample meets trig_mode on channel trig_ch:
  - rxdv rise: rxdv=1 and previous sampled rxdv=0.
  - txen rise: same rule on txen.
  - ext: trig_ext=1.
- On trigger: latch trig_ptr = wr_ptr of that write, set triggered, post_cnt = 1, go to POST. The trigger sample counts as the first post sample.
- POST: each sample_en writes; post_cnt++. The DEPTH-PRE_TRIG-th post write -> DONE.
- DONE: done=1, busy=0; no writes. Read index maps to mem[(trig_ptr - PRE_TRIG + rd_addr) mod DEPTH], so rd_addr=PRE_TRIG is the trigger sample.
- Previous rxdv/txen registers update only on sample_en. Gaps between strobes never create edges.
- abort in any state -> IDLE; done, triggered, busy cleared. Buffer contents are left undefined-for-read.
- arm while busy: ignored. abort and arm in the same cycle: abort wins.
- Trigger on the same sample_en as the PRE->WAIT transition: ignored, because that write belongs to PRE.
- rd_addr outside the captured range is legal. The modulo mapping wraps silently.

## Timing
- busy rises the cycle after arm. Trigger detection is combinational on the write cycle; triggered rises the next cycle.
- done rises, and busy falls, the cycle after the final post write.
- rd_data is registered: it reflects rd_addr one cycle later and holds while rd_addr is stable. Reads are permitted in any state; they are valid only when done=1.
- Throughput: one sample per clk. sample_en may be asserted continuously.
- Buffer: single-clock simple dual-port RAM, synchronous write, registered read; inferable as LSRAM/uSRAM.

## Test plan
- CHANNELS=2, DEPTH=16, PRE_TRIG=4, sample_en continuous: arm, drive ch0 rxd=counter 0..F with rxdv rising at counter value 9. Required: done after 12 post samples; rd_addr 0..3 = 5..8, rd_addr 4 = 9 with rxdv=1.
- trig_mode=1, trig_ch=1: ch0 rxdv toggling, ch1 txen rises on the 20th sample. Required: trigger only on ch1 txen; rd_addr 4 holds ch1 txen=1, rd_addr 3 holds ch1 txen=0.
- sample_en every 4th cycle, rxdv held high between strobes and low on one strobe: exactly one trigger, on the strobe after the low one; no writes on non-strobe cycles.
- rxdv rise within the first 4 strobes after arm: no trigger. A second rise at strobe 7 triggers, trig_ptr=6.
- abort asserted in POST with post_cnt=5: next cycle IDLE, busy=0, done=0, triggered=0. A subsequent arm runs a clean capture.
- rst_n asserted mid-POST: all outputs 0 immediately (asynchronous). After release the block is in IDLE and ignores triggers until arm.
